// File: rtl/serial_feeder_pkg.sv
// Shared state encoding, default width and counter-width helper for the serial bit feeder.
package serial_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bits needed to index 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/feeder_hold_reg.sv
// One-entry holding register with a valid flag, used to queue the next word behind the shifter.
module feeder_hold_reg
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    // NOTE: the data word is cleared on reset too, so a discarded word can never resurface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            full <= 1'b0;
        end else if (load) begin
            q    <= d;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder, MSB first, with a one-word holding register.
// Define SERIAL_BIT_FEEDER_PARITY_EN to append an even-parity bit after each word.
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    localparam logic DONE_ON_LSB = 1'b0;
`else
    localparam logic DONE_ON_LSB = 1'b1;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] next_word;
    logic [CW-1:0]    bit_cnt;
    logic             hold_full;
    logic             accept;
    logic             end_of_word;
    logic             take_hold;
    logic             take_din;
    logic             to_hold;
    logic             load_shift;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    logic             par;
`endif

    assign din_ready = !hold_full;
    assign busy      = (state != ST_IDLE) || hold_full;

    // End of word is the edge leaving the final bit on x; a new word may load there without a gap.
    always_comb begin
        accept = din_valid && !hold_full;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        end_of_word = (state == ST_PARITY);
`else
        end_of_word = (state == ST_SHIFT) && (bit_cnt == '0);
`endif
        take_hold  = end_of_word && hold_full;
        take_din   = accept && ((state == ST_IDLE) || (end_of_word && !hold_full));
        to_hold    = accept && !take_din;
        load_shift = take_hold || take_din;
        next_word  = take_hold ? hold_q : din;
    end

    feeder_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk    (clk),
        .rst    (rst),
        .load   (to_hold),
        .unload (take_hold),
        .d      (din),
        .q      (hold_q),
        .full   (hold_full)
    );

    // NOTE: all state here is updated with <= so every branch sees the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            if (load_shift) begin
                state   <= ST_SHIFT;
                x       <= next_word[WIDTH-1];
                x_valid <= 1'b1;
                shreg   <= next_word << 1;
                bit_cnt <= LAST_IDX;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
                par     <= ^next_word;
`endif
            end else begin
                case (state)
                    ST_SHIFT: begin
                        if (bit_cnt != '0) begin
                            x         <= shreg[WIDTH-1];
                            shreg     <= shreg << 1;
                            bit_cnt   <= bit_cnt - 1'b1;
                            word_done <= DONE_ON_LSB && (bit_cnt == CW'(1));
                        end else begin
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
                            state     <= ST_PARITY;
                            x         <= par;
                            word_done <= 1'b1;
`else
                            state     <= ST_IDLE;
                            x         <= IDLE_BIT;
                            x_valid   <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        x       <= IDLE_BIT;
                        x_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Upstream stage for the serial sequence detectors (e.g. the 111010 detector).
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first, one bit per clk, onto a single-bit stream `x` with a qualifying `x_valid`.
- A one-word holding register lets back-to-back words stream with no idle bubble.

Parameters:
- WIDTH, 8, word width in bits (min 2).
- IDLE_BIT, 1'b0, value driven on `x` when no bit is valid.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to serialise.
- din_valid  input  1  `din` is valid this cycle.
- din_ready  output  1  feeder can accept a word this cycle.
- x  output  1  serial bit, registered.
- x_valid  output  1  `x` carries a real data bit this cycle.
- busy  output  1  shifter or holding register occupied.
- word_done  output  1  one-cycle pulse coincident with the last bit of a word on `x`.

Behaviour:
- Reset is asynchronous and active-high on rst, single clock clk.
  - On reset: `x`=IDLE_BIT, `x_valid`=0, `din_ready`=1, `busy`=0, `word_done`=0.
  - Shifter, holding register and bit counter are cleared; state is IDLE.
- Handshake:
  - A word is accepted at a rising edge where `din_valid`=1 and `din_ready`=1.
  - `din_ready` = !hold_full and is registered-state derived, with no combinational path from `din_valid`.
- States:
  - IDLE: shifter empty.
  - SHIFT: shifting a word.
  - PARITY: only with the optional feature.
- IDLE:
  - An accepted word loads the shifter directly and moves to SHIFT.
  - The MSB appears on `x` with `x_valid`=1 in the cycle after acceptance, so latency is 1 clk.
- SHIFT:
  - Each clk presents the next bit, MSB to LSB, for exactly WIDTH consecutive cycles.
  - `bit_cnt` counts down from WIDTH-1 to 0.
- Acceptance during SHIFT:
  - If the shifter is on its last bit and hold is empty, the accepted word goes straight to the shifter, with no gap.
  - Otherwise the accepted word goes to hold and `din_ready` drops.
- Last bit (`bit_cnt`=0):
  - `word_done`=1.
  - If hold is full, its word moves to the shifter at that edge, `din_ready` rises next cycle, and the next MSB follows with no gap.
  - If hold is empty and no word is accepted, go to IDLE: `x`=IDLE_BIT, `x_valid`=0.
- `busy` = (state!=IDLE) | hold_full.
- Capacity:
  - At most one word in the shifter and one in hold.
  - No word is dropped or duplicated.
  - `din` is ignored when `din_ready`=0.
- Reset mid-word: the partial word and the held word are discarded immediately and asynchronously. Outputs go to their reset values without waiting for clk.
- `x` and `x_valid` are driven only from flops and never glitch.

Optional Feature:
- Macro SERIAL_BIT_FEEDER_PARITY_EN.
- Defined:
  - After the LSB, state PARITY emits one even-parity bit, the XOR of the word's WIDTH bits, with `x_valid`=1.
  - `word_done` pulses on the parity bit instead of the LSB.
  - Word period is WIDTH+1 cycles.
  - Hold-to-shifter transfer happens at the end of PARITY.
- Undefined:
  - No PARITY state; word period is WIDTH cycles.
  - Port list is identical in both builds.

Decomposition:
- Package serial_feeder_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2.
  - Default WIDTH.
  - Counter-width function clog2.
- Sub-module feeder_hold_reg: one-entry holding register with valid flag, load/unload strobes and async reset. The shifter/FSM lives in serial_bit_feeder.

Test Plan:
- Single word: din=8'hE8 accepted at cycle 0 -> `x`=1,1,1,0,1,0,0,0 with `x_valid`=1 in cycles 1-8. `word_done` pulses at cycle 8, then `x`=IDLE_BIT with `x_valid`=0. When chained into the 111010 detector, its `y` fires at cycle 6.
- Back-to-back: 8'hFF then 8'h00 with `din_valid` held high -> 16 contiguous valid bits, no gap. `din_ready` low for exactly one accept window while hold is full.
- Backpressure: three words offered continuously -> the third is accepted only after the first's `word_done`. Output order is FF, 00, then the third word, with none lost.
- Reset mid-word: rst asserted asynchronously mid-cycle during bit 3 of 8'hA5 -> `x_valid`=0 and `busy`=0 immediately, with no residual bits after release. The next word starts cleanly at its MSB.
- Idle/invalid: `din_valid`=1 while `din_ready`=0 -> din changes are ignored and the held word is serialised unchanged.
- PARITY_EN build: din=8'h07 -> 0,0,0,0,0,1,1,1 then parity 1. `word_done` is on the 9th bit, and the next word starts at cycle 10.
